// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package instr_fetch_buffer_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic {FETCH_RUN, FETCH_DRAIN} fetch_state_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction
endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush wins over push and pop.
module instr_fetch_buffer_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch address generator with credit-limited requests, in-order response
// buffering and redirect handling that discards responses from the old stream.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         imem_req_valid,
    output logic [PC_W-1:0]              imem_req_addr,
    input  logic                         imem_req_ready,
    input  logic                         imem_rsp_valid,
    input  logic [INSTR_W-1:0]           imem_rsp_data,
    output logic                         out_valid,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [PC_W-1:0]              out_pc,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_t          state_reg;
    logic [PC_W-1:0]       fetch_pc_reg;
    logic [PC_W-1:0]       rsp_pc_reg;
    logic [CW-1:0]         outstanding_reg;
    logic [CW-1:0]         drop_cnt_reg;
    logic [CW-1:0]         outstanding_next;
    logic [CW-1:0]         count;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  push;
    logic                  pop;
    logic [PC_W+INSTR_W-1:0] head;

    // Every in-flight request holds a reserved buffer slot, so pushes never overflow.
    assign imem_req_valid = (state_reg == FETCH_RUN) &&
                            (({1'b0, outstanding_reg} + {1'b0, count}) < DEPTH_W);
    assign imem_req_addr  = fetch_pc_reg;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outstanding_reg != '0);
    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);

    assign push = rsp_fire && (state_reg == FETCH_RUN);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH_RUN;
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old stream and must be dropped.
            fetch_pc_reg    <= align_pc(redirect_pc);
            rsp_pc_reg      <= align_pc(redirect_pc);
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= outstanding_next;
            state_reg       <= (outstanding_next != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            outstanding_reg <= outstanding_next;
            if (req_fire) fetch_pc_reg <= fetch_pc_reg + PC_INC;
            case (state_reg)
                FETCH_RUN: begin
                    if (rsp_fire) rsp_pc_reg <= rsp_pc_reg + PC_INC;
                end
                FETCH_DRAIN: begin
                    if (rsp_fire) begin
                        drop_cnt_reg <= drop_cnt_reg - CW'(1);
                        if (drop_cnt_reg == CW'(1)) state_reg <= FETCH_RUN;
                    end
                end
                default: state_reg <= FETCH_RUN;
            endcase
        end
    end

    instr_fetch_buffer_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc_reg, imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head[PC_W+INSTR_W-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];
    assign occupancy = count;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomized and directed bench for instr_fetch_buffer against a queue-based
// model of memory requests and buffered instruction/PC pairs.
module tb_instr_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  occupancy;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model: requests in flight at the memory, and the instructions decode should see.
    req_t        memq[$];
    ent_t        bufq[$];
    logic [31:0] fpc;
    bit          model_ok;
    int          cyc;
    logic [31:0] dut_pops[$];

    int n_pass;
    int n_total;

    int          ready_pct;
    int          oready_pct;
    int          redir_permil;
    int          lat_min;
    int          lat_max;
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (memq[i]) if (memq[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle();
        bit   exp_rv;
        bit   req_fire;
        bit   rsp_now;
        bit   pop_now;
        req_t r;
        req_t nr;
        ent_t e;
        // Drive this cycle's inputs.
        imem_req_ready = ($urandom_range(99) < ready_pct);
        out_ready      = ($urandom_range(99) < oready_pct);
        redirect_valid = force_redir || (!rst && ($urandom_range(999) < redir_permil));
        redirect_pc    = force_redir ? force_pc : $urandom;
        force_redir    = 1'b0;
        imem_rsp_valid = !rst && (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mem_word(memq[0].addr) : $urandom;

        @(negedge clk);
        assert (!(imem_rsp_valid && memq.size() == 0))
            else $error("response driven with nothing outstanding");
        exp_rv = (n_stale() == 0) && ((memq.size() + bufq.size()) < DEPTH);
        if (model_ok) begin
            chk("out_valid", 32'(out_valid), 32'(bufq.size() != 0));
            chk("occupancy", 32'(occupancy), 32'(bufq.size()));
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", imem_req_addr, fpc);
            if (bufq.size() != 0) begin
                chk("out_pc", out_pc, bufq[0].pc);
                chk("out_instr", out_instr, bufq[0].instr);
            end
        end
        if (out_valid && out_ready && !rst) dut_pops.push_back(out_pc);
        req_fire = exp_rv && imem_req_ready;
        rsp_now  = imem_rsp_valid;
        pop_now  = (bufq.size() != 0) && out_ready;

        @(posedge clk);
        if (rst) begin
            memq.delete();
            bufq.delete();
            fpc      = RESET_PC;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (rsp_now) r = memq.pop_front();
            nr.addr  = fpc;
            nr.due   = cyc + $urandom_range(lat_max, lat_min);
            if (memq.size() > 0 && memq[memq.size()-1].due > nr.due)
                nr.due = memq[memq.size()-1].due;
            nr.stale = redirect_valid;
            if (redirect_valid) begin
                foreach (memq[i]) memq[i].stale = 1'b1;
                if (req_fire) memq.push_back(nr);
                bufq.delete();
                fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop_now) void'(bufq.pop_front());
                if (rsp_now && !r.stale) begin
                    e.pc    = r.addr;
                    e.instr = mem_word(r.addr);
                    bufq.push_back(e);
                end
                if (req_fire) begin
                    memq.push_back(nr);
                    fpc = fpc + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; model_ok = 1'b0;
        fpc = RESET_PC;
        ready_pct = 100; oready_pct = 100; redir_permil = 0;
        lat_min = 1; lat_max = 1; force_redir = 1'b0; force_pc = '0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;

        // Reset state
        cycle();
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_req_addr", imem_req_addr, RESET_PC);

        // 1-cycle memory, decode always ready: gapless stream from address 0
        dut_pops.delete();
        cycle();
        chk("t1_second_addr", imem_req_addr, 32'h0000_0004);
        cycle();
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_pc", out_pc, 32'h0000_0000);
        chk("t1_first_instr", out_instr, mem_word(32'h0));
        repeat (10) cycle();
        chk("t1_pop_count", 32'(dut_pops.size()), 32'd10);
        for (int i = 0; i < dut_pops.size(); i++) chk("t1_pop_pc", dut_pops[i], 32'(4 * i));

        // Decode stalled: credit limit of DEPTH, then one pop frees one request
        do_reset();
        oready_pct = 0;
        repeat (8) cycle();
        chk("t2_full_occ", 32'(occupancy), 32'd4);
        chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        oready_pct = 100;
        cycle();
        oready_pct = 0;
        chk("t2_after_pop_req_valid", 32'(imem_req_valid), 32'd1);
        cycle();
        chk("t2_one_more_req_valid", 32'(imem_req_valid), 32'd0);
        cycle();
        chk("t2_refilled_occ", 32'(occupancy), 32'd4);

        // Redirect with 3 outstanding to an unaligned target
        lat_min = 6; lat_max = 6; oready_pct = 100;
        do_reset();
        repeat (3) cycle();
        chk("t3_pre_req_valid", 32'(imem_req_valid), 32'd1);
        force_redir = 1'b1; force_pc = 32'h0000_0103; ready_pct = 0;
        cycle();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        chk("t3_model_stale", 32'(n_stale()), 32'd3);
        chk("t3_new_addr", imem_req_addr, 32'h0000_0100);
        chk("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
        dut_pops.delete();
        for (int i = 0; i < 40 && dut_pops.size() == 0; i++) cycle();
        chk("t3_pop_seen", 32'(dut_pops.size() != 0), 32'd1);
        if (dut_pops.size() != 0) chk("t3_first_pc", dut_pops[0], 32'h0000_0100);

        // Redirect coinciding with a response and a request acceptance
        lat_min = 2; lat_max = 2; oready_pct = 0;
        do_reset();
        cycle();
        cycle();
        force_redir = 1'b1; force_pc = 32'h0000_0200;
        cycle();
        chk("t4_model_stale", 32'(n_stale()), 32'd2);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t4_occupancy", 32'(occupancy), 32'd0);
        lat_min = 1; lat_max = 1; oready_pct = 100;
        dut_pops.delete();
        for (int i = 0; i < 40 && dut_pops.size() == 0; i++) cycle();
        chk("t4_pop_seen", 32'(dut_pops.size() != 0), 32'd1);
        if (dut_pops.size() != 0) chk("t4_first_pc", dut_pops[0], 32'h0000_0200);

        // Address wrap at the top of the address space
        do_reset();
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        cycle();
        dut_pops.delete();
        for (int i = 0; i < 40 && dut_pops.size() < 2; i++) cycle();
        chk("t5_pops_seen", 32'(dut_pops.size() >= 2), 32'd1);
        if (dut_pops.size() >= 2) begin
            chk("t5_pc0", dut_pops[0], 32'hFFFF_FFFC);
            chk("t5_pc1", dut_pops[1], 32'h0000_0000);
        end

        // Reset with buffered entries and requests still in flight
        oready_pct = 0;
        do_reset();
        cycle();
        cycle();
        lat_min = 30; lat_max = 30;
        cycle();
        cycle();
        chk("t6_pre_occ", 32'(occupancy), 32'd2);
        chk("t6_pre_req_valid", 32'(imem_req_valid), 32'd0);
        do_reset();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_occupancy", 32'(occupancy), 32'd0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, RESET_PC);

        // Random traffic
        lat_min = 1; lat_max = 5; ready_pct = 75; oready_pct = 60; redir_permil = 30;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(999) < 3);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
